// File: rtl/answer_digitizer.sv
`default_nettype none
// ============================================================================
// Module   : answer_digitizer
// Brief    : Breaks a 32-bit calculator answer into MSD-first decimal digit
//            tokens (double-dabble), leading zeros suppressed, valid/ack out.
//            Define ANSWER_DIGITIZER_SIGNED_EN for two's-complement input
//            with a leading minus token (4'hB).
// Revision : 1.0 - initial release
// ============================================================================
module answer_digitizer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        strobe,
    input  logic [31:0] value,
    output logic        ready,
    output logic        digit_valid,
    output logic [3:0]  digit,
    output logic        digit_last,
    input  logic        ack
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_CONV = 2'd1;
    localparam logic [1:0] c_SIGN = 2'd2;
    localparam logic [1:0] c_EMIT = 2'd3;

    localparam logic [3:0] c_MINUS     = 4'hB;
    localparam logic [5:0] c_CONV_LAST = 6'd32;

    logic [1:0]  r_state;
    logic        r_neg;
    logic [31:0] r_mag;
    logic [39:0] r_bcd;
    logic [5:0]  r_cnt;
    logic [3:0]  r_idx;

    logic        w_neg;
    logic [31:0] w_mag;
    logic [39:0] w_bcd_adj;
    logic [3:0]  w_top_idx;
    logic [3:0]  w_idx_dec;
    logic [3:0]  w_nib_cur;
    logic [3:0]  w_nib_dec;
    logic [3:0]  w_nib_top;

`ifdef ANSWER_DIGITIZER_SIGNED_EN
    assign w_neg = value[31];
`else
    assign w_neg = 1'b0;
`endif
    assign w_mag = w_neg ? (~value + 32'd1) : value;

    generate
        for (genvar g = 0; g < 10; g++) begin : g_nib_adj
            assign w_bcd_adj[g*4 +: 4] = (r_bcd[g*4 +: 4] >= 4'd5) ?
                                         (r_bcd[g*4 +: 4] + 4'd3) :
                                         r_bcd[g*4 +: 4];
        end
    endgenerate

    // Highest nonzero nibble; stays 0 for an all-zero result so "0" is emitted
    always_comb begin
        w_top_idx = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (r_bcd[i*4 +: 4] != 4'd0) begin
                w_top_idx = 4'(i);
            end
        end
    end

    assign w_idx_dec = r_idx - 4'd1;
    assign w_nib_cur = r_bcd[{r_idx, 2'b00} +: 4];
    assign w_nib_dec = r_bcd[{w_idx_dec, 2'b00} +: 4];
    assign w_nib_top = r_bcd[{w_top_idx, 2'b00} +: 4];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_IDLE;
            r_neg       <= 1'b0;
            r_mag       <= 32'd0;
            r_bcd       <= 40'd0;
            r_cnt       <= 6'd0;
            r_idx       <= 4'd0;
            ready       <= 1'b1;
            digit_valid <= 1'b0;
            digit       <= 4'd0;
            digit_last  <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (strobe) begin
                        r_neg   <= w_neg;
                        r_mag   <= w_mag;
                        r_bcd   <= 40'd0;
                        r_cnt   <= 6'd0;
                        r_idx   <= 4'd0;
                        ready   <= 1'b0;
                        r_state <= c_CONV;
                    end
                end
                c_CONV: begin
                    // 32 shift cycles, then one cycle to pick the leading digit
                    if (r_cnt == c_CONV_LAST) begin
                        r_idx       <= w_top_idx;
                        digit_valid <= 1'b1;
                        if (r_neg) begin
                            digit      <= c_MINUS;
                            digit_last <= 1'b0;
                            r_state    <= c_SIGN;
                        end else begin
                            digit      <= w_nib_top;
                            digit_last <= (w_top_idx == 4'd0);
                            r_state    <= c_EMIT;
                        end
                    end else begin
                        r_bcd <= {w_bcd_adj[38:0], r_mag[31]};
                        r_mag <= {r_mag[30:0], 1'b0};
                        r_cnt <= r_cnt + 6'd1;
                    end
                end
                c_SIGN: begin
                    if (ack) begin
                        digit      <= w_nib_cur;
                        digit_last <= (r_idx == 4'd0);
                        r_state    <= c_EMIT;
                    end
                end
                c_EMIT: begin
                    if (ack) begin
                        if (r_idx == 4'd0) begin
                            ready       <= 1'b1;
                            digit_valid <= 1'b0;
                            digit       <= 4'd0;
                            digit_last  <= 1'b0;
                            r_state     <= c_IDLE;
                        end else begin
                            r_idx      <= w_idx_dec;
                            digit      <= w_nib_dec;
                            digit_last <= (w_idx_dec == 4'd0);
                        end
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
